// File: rtl/rw_array_sched_if.sv
// Request, array-read and output-stream signals of the round-robin array read scheduler.
// The master side is the clients/array/downstream; the slave side is the scheduler.
interface rw_array_sched_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned NBANK = 3,
  parameter int unsigned NROW  = 2,
  parameter int unsigned NCOL  = 4,
  parameter int unsigned DW    = 11
) ();
  localparam int unsigned BW  = (NBANK > 1) ? $clog2(NBANK) : 1;
  localparam int unsigned RW  = (NROW  > 1) ? $clog2(NROW)  : 1;
  localparam int unsigned CW  = (NCOL  > 1) ? $clog2(NCOL)  : 1;
  localparam int unsigned IDW = (NREQ  > 1) ? $clog2(NREQ)  : 1;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*BW-1:0] req_bank;
  logic [NREQ-1:0]    req_ready;
  logic               arr_rd;
  logic [BW-1:0]      arr_bank;
  logic [RW-1:0]      arr_row;
  logic [CW-1:0]      arr_col;
  logic [DW-1:0]      arr_rdata;
  logic               out_valid;
  logic               out_ready;
  logic [DW-1:0]      out_data;
  logic [IDW-1:0]     out_id;
  logic               out_last;
  logic               out_err;

  modport master (
    output req_valid, req_bank, arr_rdata, out_ready,
    input  req_ready, arr_rd, arr_bank, arr_row, arr_col,
           out_valid, out_data, out_id, out_last, out_err
  );

  modport slave (
    input  req_valid, req_bank, arr_rdata, out_ready,
    output req_ready, arr_rd, arr_bank, arr_row, arr_col,
           out_valid, out_data, out_id, out_last, out_err
  );
endinterface

// File: rtl/rw_array_sched.sv
// Round-robin scheduler granting one requester at a time a full-bank burst read of the
// banked array, returning the words through a 2-entry output FIFO tagged with requester id.
module rw_array_sched #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned NBANK = 3,
  parameter int unsigned NROW  = 2,
  parameter int unsigned NCOL  = 4,
  parameter int unsigned DW    = 11
) (
  input  logic             clk,
  input  logic             rst,
  rw_array_sched_if.slave  bus
);
  localparam int unsigned BW  = (NBANK > 1) ? $clog2(NBANK) : 1;
  localparam int unsigned RW  = (NROW  > 1) ? $clog2(NROW)  : 1;
  localparam int unsigned CW  = (NCOL  > 1) ? $clog2(NCOL)  : 1;
  localparam int unsigned IDW = (NREQ  > 1) ? $clog2(NREQ)  : 1;

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_DRAIN, S_ERR} state_e;

  typedef struct packed {
    logic [DW-1:0]  data;
    logic [IDW-1:0] id;
    logic           last;
  } word_t;

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_q, rr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [BW-1:0]  bank_q, bank_d;
  logic [RW-1:0]  row_q, row_d;
  logic [CW-1:0]  col_q, col_d;

  logic           inflight_q;
  logic           inflight_last_q;
  word_t          mem_q [2];
  logic           wptr_q, rptr_q;
  logic [1:0]     cnt_q;

  logic           found_c;
  logic [IDW-1:0] win_c;
  logic [IDW-1:0] idx_c;
  logic [BW-1:0]  win_bank_c;
  logic [NREQ-1:0] req_ready_c;
  logic           pop_c;
  logic [2:0]     pend_c;
  logic           rd_c;
  logic           last_beat_c;
  word_t          head_c;

  // First valid requester at or after the round-robin pointer, wrapping.
  always_comb begin
    found_c = 1'b0;
    win_c   = '0;
    idx_c   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx_c = IDW'((32'(rr_q) + 32'(i)) % NREQ);
      if (!found_c && bus.req_valid[idx_c]) begin
        found_c = 1'b1;
        win_c   = idx_c;
      end
    end
  end

  assign win_bank_c  = bus.req_bank[32'(win_c)*BW +: BW];
  assign head_c      = mem_q[rptr_q];
  assign pop_c       = (cnt_q != 2'd0) && bus.out_ready;
  // Words buffered or in flight after this edge must never exceed the FIFO depth.
  assign pend_c      = 3'(cnt_q) + 3'(inflight_q) - 3'(pop_c);
  assign rd_c        = (state_q == S_BURST) && (pend_c < 3'd2);
  assign last_beat_c = (row_q == RW'(NROW-1)) && (col_q == CW'(NCOL-1));

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    id_d        = id_q;
    bank_d      = bank_q;
    row_d       = row_q;
    col_d       = col_q;
    req_ready_c = '0;
    unique case (state_q)
      S_IDLE: begin
        if (found_c) begin
          req_ready_c[win_c] = 1'b1;
          id_d    = win_c;
          bank_d  = win_bank_c;
          rr_d    = IDW'((32'(win_c) + 32'd1) % NREQ);
          row_d   = '0;
          col_d   = '0;
          state_d = (32'(win_bank_c) >= NBANK) ? S_ERR : S_BURST;
        end
      end
      S_BURST: begin
        if (rd_c) begin
          if (last_beat_c) begin
            state_d = S_DRAIN;
          end else if (col_q == CW'(NCOL-1)) begin
            col_d = '0;
            row_d = row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (pop_c && head_c.last) state_d = S_IDLE;
      end
      S_ERR: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      id_q    <= '0;
      bank_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      bank_q  <= bank_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  // Read data lands one cycle after the strobe and is pushed with the burst tag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      wptr_q          <= 1'b0;
      rptr_q          <= 1'b0;
      cnt_q           <= 2'd0;
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
    end else begin
      inflight_q      <= rd_c;
      inflight_last_q <= rd_c && last_beat_c;
      if (inflight_q) begin
        mem_q[wptr_q] <= '{data: bus.arr_rdata, id: id_q, last: inflight_last_q};
        wptr_q        <= ~wptr_q;
      end
      if (pop_c) rptr_q <= ~rptr_q;
      cnt_q <= cnt_q + 2'(inflight_q) - 2'(pop_c);
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.arr_rd    = rd_c;
  assign bus.arr_bank  = (state_q == S_BURST) ? bank_q : '0;
  assign bus.arr_row   = (state_q == S_BURST) ? row_q  : '0;
  assign bus.arr_col   = (state_q == S_BURST) ? col_q  : '0;
  assign bus.out_valid = (cnt_q != 2'd0);
  assign bus.out_data  = head_c.data;
  assign bus.out_id    = head_c.id;
  assign bus.out_last  = head_c.last;
  assign bus.out_err   = (state_q == S_ERR);
endmodule

// File: tb/tb_rw_array_sched.sv
// Directed bench for rw_array_sched: a transaction-level model of arbitration and burst
// contents is checked every cycle, plus hand-computed literals for each scenario.
module tb_rw_array_sched;
  localparam int unsigned NREQ = 4, NBANK = 3, NROW = 2, NCOL = 4, DW = 11;
  localparam int unsigned BL = NROW * NCOL;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rw_array_sched_if #(.NREQ(NREQ), .NBANK(NBANK), .NROW(NROW), .NCOL(NCOL), .DW(DW)) bus ();

  rw_array_sched #(.NREQ(NREQ), .NBANK(NBANK), .NROW(NROW), .NCOL(NCOL), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            id;
    logic          last;
    int            cyc;
  } word_t;

  int    errors = 0, checks = 0;
  word_t exp_q[$];
  word_t acc_log[$];
  int    grant_log[$];
  int    rr_m = 0, cur_bank = 0, rd_k = BL, cyc = 0;
  int    issued = 0, accepted = 0, err_seen = 0;
  bit    busy = 1'b0, err_exp = 1'b0, prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic [1:0]    prev_id;
  logic          prev_last;

  function automatic logic [DW-1:0] f(input int b, input int r, input int c);
    return 11'(b*256 + r*64 + c*8 + 5);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Array: data for a strobed address appears one cycle later, junk otherwise.
  always @(posedge clk) begin
    if (bus.arr_rd) bus.arr_rdata <= f(int'(bus.arr_bank), int'(bus.arr_row), int'(bus.arr_col));
    else            bus.arr_rdata <= 11'h5A5;
  end

  // Transaction model and per-cycle compare.
  always @(negedge clk) begin : cmp
    int w;
    int b;
    word_t e;
    word_t a;
    cyc++;
    if (!rst) begin
      exp_q.delete();
      rr_m = 0; busy = 1'b0; err_exp = 1'b0; rd_k = BL;
      issued = 0; accepted = 0; prev_stall = 1'b0;
    end else begin
      if (err_exp || bus.out_err) begin
        chk("out_err", 32'(bus.out_err), 32'(err_exp));
        if (bus.out_err) err_seen++;
        if (err_exp) busy = 1'b0;
        err_exp = 1'b0;
      end
      if (bus.req_ready != '0) begin
        w = -1;
        for (int i = 0; i < NREQ; i++)
          if (w < 0 && bus.req_valid[(rr_m + i) % NREQ]) w = int'((rr_m + i) % NREQ);
        chk("grant_while_busy", 32'(busy), 32'd0);
        chk("grant_vector", 32'(bus.req_ready), (w < 0) ? 32'd0 : (32'd1 << w));
        if (w >= 0) begin
          b = int'(bus.req_bank[w*2 +: 2]);
          grant_log.push_back(w);
          rr_m = int'((w + 1) % NREQ);
          busy = 1'b1;
          if (b >= NBANK) begin
            err_exp = 1'b1;
            rd_k    = BL;
          end else begin
            cur_bank = b;
            rd_k     = 0;
            for (int k = 0; k < BL; k++) begin
              e.data = f(b, int'(k / NCOL), int'(k % NCOL));
              e.id   = w;
              e.last = (k == BL - 1);
              e.cyc  = 0;
              exp_q.push_back(e);
            end
          end
        end
      end
      if (prev_stall) begin
        chk("stall_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_data",  32'(bus.out_data),  32'(prev_data));
        chk("stall_id",    32'(bus.out_id),    32'(prev_id));
        chk("stall_last",  32'(bus.out_last),  32'(prev_last));
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_id    = bus.out_id;
      prev_last  = bus.out_last;
      if (bus.arr_rd) begin
        issued++;
        chk("rd_in_burst", 32'(busy && rd_k < BL), 32'd1);
        if (busy && rd_k < BL) begin
          chk("arr_bank", 32'(bus.arr_bank), 32'(cur_bank));
          chk("arr_row",  32'(bus.arr_row),  32'(rd_k / NCOL));
          chk("arr_col",  32'(bus.arr_col),  32'(rd_k % NCOL));
          rd_k++;
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        accepted++;
        chk("word_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("out_data", 32'(bus.out_data), 32'(e.data));
          chk("out_id",   32'(bus.out_id),   32'(e.id));
          chk("out_last", 32'(bus.out_last), 32'(e.last));
          a.data = bus.out_data; a.id = int'(bus.out_id); a.last = bus.out_last; a.cyc = cyc;
          acc_log.push_back(a);
          if (e.last) busy = 1'b0;
        end
      end
      if (bus.arr_rd) chk("occupancy_le2", 32'((issued - accepted) <= 2), 32'd1);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_grant(input int id, input logic [3:0] vec);
    int n;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!bus.req_ready[id] && n < 50);
    chk("grant_literal", 32'(bus.req_ready), 32'(vec));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while ((busy || exp_q.size() != 0) && n < 300);
    chk("burst_complete", 32'(!busy && exp_q.size() == 0), 32'd1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
    chk({tag, "_arr_rd"},    32'(bus.arr_rd),    32'd0);
    chk({tag, "_arr_addr"},  32'({bus.arr_bank, bus.arr_row, bus.arr_col}), 32'd0);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_out_word"},  32'({bus.out_data, bus.out_id, bus.out_last}), 32'd0);
    chk({tag, "_out_err"},   32'(bus.out_err),   32'd0);
  endtask

  initial begin : stim
    int c;
    int iss0;
    bus.req_valid = '0; bus.req_bank = '0; bus.out_ready = 1'b0;
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #3 rst = 1'b1;

    // All four requesting: rr order 0,1,2,3,0 with whole bursts back to back.
    step();
    bus.req_bank = {2'd0, 2'd2, 2'd1, 2'd0};
    bus.out_ready = 1'b1; grant_log.delete(); acc_log.delete();
    bus.req_valid = 4'b1111;
    c = 0;
    while (grant_log.size() < 5 && c < 400) begin @(negedge clk); #1; c++; end
    step(); bus.req_valid = '0;
    wait_idle();
    chk("t2_grants", 32'(grant_log.size()), 32'd5);
    if (grant_log.size() >= 5) begin
      chk("t2_g0", 32'(grant_log[0]), 32'd0);
      chk("t2_g1", 32'(grant_log[1]), 32'd1);
      chk("t2_g2", 32'(grant_log[2]), 32'd2);
      chk("t2_g3", 32'(grant_log[3]), 32'd3);
      chk("t2_g4", 32'(grant_log[4]), 32'd0);
    end
    chk("t2_words", 32'(acc_log.size()), 32'd40);

    // Single request: id 2, bank 1, continuous drain.
    step(); acc_log.delete();
    bus.req_bank = 8'b00_01_00_00; bus.req_valid = 4'b0100;
    wait_grant(2, 4'b0100);
    step(); bus.req_valid = '0;
    @(negedge clk);
    chk("t1_ready_pulse", 32'(bus.req_ready), 32'd0);
    wait_idle();
    chk("t1_words", 32'(acc_log.size()), 32'd8);
    if (acc_log.size() == 8) begin
      chk("t1_first_data", 32'(acc_log[0].data), 32'd261);
      chk("t1_last_data",  32'(acc_log[7].data), 32'd349);
      chk("t1_id",         32'(acc_log[0].id),   32'd2);
      chk("t1_mid_last",   32'(acc_log[3].last), 32'd0);
      chk("t1_last_flag",  32'(acc_log[7].last), 32'd1);
      chk("t1_back_to_back", 32'(acc_log[7].cyc - acc_log[0].cyc), 32'd7);
    end

    // Out-of-range bank: error pulse only.
    step(); acc_log.delete(); err_seen = 0; iss0 = issued;
    bus.req_bank = 8'b00_00_11_00; bus.req_valid = 4'b0010;
    wait_grant(1, 4'b0010);
    step(); bus.req_valid = '0;
    repeat (5) @(negedge clk);
    #1;
    chk("t4_err_pulses", 32'(err_seen), 32'd1);
    chk("t4_no_reads", 32'(issued - iss0), 32'd0);
    chk("t4_no_words", 32'(acc_log.size()), 32'd0);
    chk("t4_out_valid", 32'(bus.out_valid), 32'd0);

    // Back-pressure pattern 1,0,0,1 on one burst from id 3, bank 0.
    step(); acc_log.delete();
    bus.req_bank = 8'b00_00_00_00; bus.req_valid = 4'b1000;
    wait_grant(3, 4'b1000);
    step(); bus.req_valid = '0;
    c = 0;
    do begin
      bus.out_ready = (c % 4 == 0) || (c % 4 == 3);
      @(negedge clk); #1; c++;
      if (!busy && exp_q.size() == 0) break;
      step();
    end while (c < 300);
    chk("t3_done", 32'(!busy && exp_q.size() == 0), 32'd1);
    chk("t3_words", 32'(acc_log.size()), 32'd8);
    if (acc_log.size() == 8) begin
      chk("t3_w0", 32'(acc_log[0].data), 32'd5);
      chk("t3_w5", 32'(acc_log[5].data), 32'd77);
      chk("t3_w7", 32'(acc_log[7].data), 32'd93);
    end

    // Downstream stalled from the start: exactly two reads, r0c0 held at the head.
    step(); acc_log.delete(); bus.out_ready = 1'b0;
    bus.req_bank = 8'b00_10_00_00; bus.req_valid = 4'b0100;
    wait_grant(2, 4'b0100);
    iss0 = issued;
    step(); bus.req_valid = '0;
    repeat (8) @(negedge clk);
    #1;
    chk("t6_reads", 32'(issued - iss0), 32'd2);
    chk("t6_valid", 32'(bus.out_valid), 32'd1);
    chk("t6_head",  32'(bus.out_data), 32'd517);
    step(); bus.out_ready = 1'b1;
    wait_idle();
    chk("t6_words", 32'(acc_log.size()), 32'd8);

    // Reset after the third word of a burst from id 1.
    step(); acc_log.delete();
    bus.req_bank = 8'b00_00_01_00; bus.req_valid = 4'b0010;
    wait_grant(1, 4'b0010);
    step(); bus.req_valid = '0;
    c = 0;
    while (acc_log.size() < 3 && c < 50) begin @(negedge clk); #1; c++; end
    chk("t5_three_words", 32'(acc_log.size()), 32'd3);
    @(posedge clk); #3 rst = 1'b0;
    #1 check_zero("t5_async");
    @(posedge clk); @(posedge clk); #3 rst = 1'b1;
    step(); acc_log.delete(); grant_log.delete();
    bus.req_bank = {2'd0, 2'd2, 2'd1, 2'd0}; bus.req_valid = 4'b1111;
    wait_grant(0, 4'b0001);
    step(); bus.req_valid = '0;
    wait_idle();
    chk("t5_words", 32'(acc_log.size()), 32'd8);
    if (acc_log.size() == 8) begin
      chk("t5_id",   32'(acc_log[0].id),   32'd0);
      chk("t5_data", 32'(acc_log[0].data), 32'd5);
      chk("t5_last", 32'(acc_log[7].last), 32'd1);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
